// File: rtl/light_seq_ctrl.sv
// light_seq_ctrl: button conditioning and advance sequencing for the LED colour stepper
module light_seq_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PERIOD_W        = 16,
    parameter int CNT_W           = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_raw,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    output logic                adv,
    output logic                btn_db,
    output logic                paused,
    output logic [CNT_W-1:0]    adv_count
);
    localparam logic [1:0] M_OFF  = 2'b00;
    localparam logic [1:0] M_HOLD = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;
    localparam logic [1:0] M_AUTO = 2'b11;
    localparam logic [7:0] DBC_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic                s1_q, s2_q;
    logic                db_q, db_d, db_dly_q;
    logic [7:0]          dbc_q, dbc_d;
    logic [1:0]          mode_q;
    logic [PERIOD_W-1:0] tick_q, tick_d;
    logic                adv_q, adv_d;
    logic                paused_q, paused_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                differs, rise, mode_chg, auto_hit;

    assign differs  = s2_q != db_q;
    assign rise     = db_q & ~db_dly_q;
    assign mode_chg = mode != mode_q;
    assign auto_hit = (tick_q == period) & ~paused_q;

    // Debounce: flip the stable level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        db_d  = (differs && dbc_q == DBC_LAST) ? ~db_q : db_q;
        dbc_d = (differs && dbc_q != DBC_LAST) ? dbc_q + 8'd1 : 8'd0;
    end

    // Advance decision per mode; a mode change suppresses everything for one cycle
    always_comb begin
        adv_d    = (mode_chg || mode == M_OFF) ? 1'b0 :
                   mode == M_HOLD ? db_q :
                   mode == M_STEP ? rise : auto_hit;
        tick_d   = (mode_chg || mode != M_AUTO) ? '0 :
                   paused_q ? tick_q :
                   (tick_q >= period) ? '0 : tick_q + PERIOD_W'(1);
        paused_d = (mode == M_AUTO && !mode_chg) ? paused_q ^ rise : 1'b0;
    end

    // State registers; a held button must re-debounce after reset because the sync flops clear too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            dbc_q    <= 8'd0;
            mode_q   <= M_OFF;
            tick_q   <= '0;
            adv_q    <= 1'b0;
            paused_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn_raw;
            s2_q     <= s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            dbc_q    <= dbc_d;
            mode_q   <= mode;
            tick_q   <= tick_d;
            adv_q    <= adv_d;
            paused_q <= paused_d;
            cnt_q    <= cnt_q + CNT_W'(adv_q);
        end
    end

    assign adv       = adv_q;
    assign btn_db    = db_q;
    assign paused    = paused_q;
    assign adv_count = cnt_q;
endmodule

// File: tb/tb_light_seq_ctrl.sv
// tb_light_seq_ctrl: scoreboard bench for light_seq_ctrl against a behavioural model
module tb_light_seq_ctrl;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_raw = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] period = 16'd0;
    logic        adv, btn_db, paused;
    logic [7:0]  adv_count;

    light_seq_ctrl #(.DEBOUNCE_CYCLES(N), .PERIOD_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .mode(mode), .period(period),
        .adv(adv), .btn_db(btn_db), .paused(paused), .adv_count(adv_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       adv;
        logic       db;
        logic       paused;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    // Model state: raw-sample history (two sync stages plus debounce window), mode rules
    bit [N+1:0] rh;
    bit         m_db, m_dbp, m_adv, m_paused, m_rise, m_chg, m_flip, m_adv_n, m_paused_n;
    bit [1:0]   m_mode;
    int         m_tick, m_tick_n, m_cnt;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            rh = '0; m_db = 0; m_dbp = 0; m_adv = 0; m_paused = 0;
            m_mode = 0; m_tick = 0; m_cnt = 0;
        end else begin
            m_rise = m_db && !m_dbp;
            m_chg  = mode != m_mode;
            m_flip = 1;
            for (int j = 1; j <= N; j++) if (rh[j] == m_db) m_flip = 0;
            m_adv_n = m_chg ? 1'b0 : mode == 2'd1 ? m_db : mode == 2'd2 ? m_rise :
                      mode == 2'd3 ? (m_tick == int'(period) && !m_paused) : 1'b0;
            m_tick_n = (m_chg || mode != 2'd3) ? 0 : m_paused ? m_tick :
                       (m_tick >= int'(period)) ? 0 : m_tick + 1;
            m_paused_n = (mode == 2'd3 && !m_chg) ? m_paused ^ m_rise : 1'b0;
            m_cnt    = (m_cnt + int'(m_adv)) % 256;
            m_dbp    = m_db;
            m_db     = m_db ^ m_flip;
            m_adv    = m_adv_n;
            m_tick   = m_tick_n;
            m_paused = m_paused_n;
            m_mode   = mode;
            rh       = {rh[N:0], btn_raw};
        end
        sb.push_back({m_adv, m_db, m_paused, 8'(m_cnt)});
    end

    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("outputs{adv,db,paused,cnt}", {21'd0, adv, btn_db, paused, adv_count}, {21'd0, mon_e});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic run(input bit r, input bit [1:0] m, input int p, input int n);
        btn_raw = r;
        mode    = m;
        period  = 16'(p);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int lat;
    bit rr;
    bit [1:0] rm;
    int rp;

    initial begin
        @(negedge clk);
        #1;
        run(0, 0, 0, 3);
        rst = 0;
        run(0, 0, 0, 3);
        chk("idle_zero", {21'd0, adv, btn_db, paused, adv_count}, 0);
        run(1, 0, 0, 3);
        run(0, 0, 0, 10);
        chk("glitch_db", btn_db, 0);
        btn_raw = 1;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (btn_db) lat = i;
        end
        chk("db_latency", lat, N + 2);
        @(negedge clk);
        #1;
        run(1, 1, 0, 21);
        run(0, 1, 0, 10);
        repeat (3) begin
            run(1, 2, 0, 10);
            run(0, 2, 0, 10);
        end
        run(0, 3, 4, 22);
        run(1, 3, 4, 10);
        run(0, 3, 4, 15);
        run(1, 3, 4, 10);
        run(0, 3, 4, 20);
        run(1, 3, 4, 10);
        run(0, 3, 4, 4);
        chk("paused_set", paused, 1);
        run(0, 2, 4, 1);
        chk("switch_unpause", paused, 0);
        chk("switch_adv", adv, 0);
        run(0, 3, 0, 3);
        repeat (8) begin
            run(0, 3, 0, 1);
            chk("p0_adv", adv, 1);
        end
        run(0, 3, 1, 6);
        rst = 1;
        #1;
        chk("rst_async", {21'd0, adv, btn_db, paused, adv_count}, 0);
        run(0, 3, 1, 2);
        rst = 0;
        run(0, 0, 0, 5);
        chk("idle_after_rst", {21'd0, adv, btn_db, paused, adv_count}, 0);
        run(1, 1, 0, 10);
        rst = 1;
        run(1, 1, 0, 2);
        rst = 0;
        run(1, 1, 0, 8);
        run(0, 0, 0, 8);
        rst = 1;
        run(0, 0, 0, 2);
        rst = 0;
        run(1, 0, 0, 8);
        run(1, 1, 0, 257);
        chk("cnt_255", adv_count, 255);
        run(1, 1, 0, 1);
        chk("cnt_wrap", adv_count, 0);
        run(0, 0, 0, 8);
        rr = 0;
        for (int s = 0; s < 40; s++) begin
            rm = 2'($urandom_range(0, 3));
            rp = int'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1;
                run(rr, rm, rp, 2);
                rst = 0;
            end
            for (int k = 0; k < 6; k++) begin
                rr = ~rr;
                run(rr, rm, rp, int'($urandom_range(1, 12)));
            end
        end
        run(0, 0, 0, 4);
        chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
